// File: rtl/chr_sram_loader_pkg.sv
// Shared types and default image geometry for the CHR boot loader.
// Purpose: state encoding plus default flash base and CHR word count.
// Ports: none (package only).
package nes_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_SETUP,
    S_WE,
    S_HOLD,
    S_DONE
  } loader_state_t;

  // Flash byte address of CHR byte 0.
  localparam logic [22:0] CHR_FL_BASE = 23'h400000;
  // 8 KB of CHR packed as 16-bit words.
  localparam int unsigned CHR_WORDS   = 4096;

endpackage

// File: rtl/chr_sram_loader.sv
// Purpose: boot-time copy of the CHR image from 8-bit NOR flash into 16-bit async SRAM.
// Latency: o_busy rises the edge after i_start; 2*FL_WAIT+WE_CYC+2 cycles per word.
// Backpressure: none; i_start is ignored while busy, the copy runs at a fixed rate.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   i_start             start pulse, honoured only in IDLE or DONE
//   o_busy, o_done      copy in progress / sticky completion flag
//   o_fl_*, i_fl_dq     flash address, chip/output enables, read data
//   o_sram_*            SRAM word address, write data, tristate enable, controls
module chr_sram_loader
  import nes_loader_pkg::*;
#(
  parameter logic [22:0] FL_BASE   = CHR_FL_BASE,
  parameter logic [19:0] SRAM_BASE = 20'h00000,
  parameter int unsigned LEN_WORDS = CHR_WORDS,
  parameter int unsigned FL_WAIT   = 5,
  parameter int unsigned WE_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [22:0] o_fl_addr,
  output logic        o_fl_ce_n,
  output logic        o_fl_oe_n,
  input  logic [7:0]  i_fl_dq,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_dq,
  output logic        o_sram_dq_oe,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam logic [19:0] LAST_IDX = 20'(LEN_WORDS - 1);
  localparam logic [15:0] FL_LAST  = 16'(FL_WAIT - 1);
  localparam logic [15:0] WE_LAST  = 16'(WE_CYC - 1);

  loader_state_t state_q;
  logic [19:0]   idx_q;
  logic [15:0]   cnt_q;
  logic [7:0]    lo_q;
  logic          busy_q;
  logic          done_q;
  logic [22:0]   fl_addr_q;
  logic          fl_ce_n_q;
  logic          fl_oe_n_q;
  logic [19:0]   sram_addr_q;
  logic [15:0]   sram_dq_q;
  logic          dq_oe_q;
  logic          sram_ce_n_q;
  logic          we_n_q;
  logic          bytes_n_q;

  logic [19:0]   idx_inc;
  logic [22:0]   fl_next_addr;

  assign idx_inc      = idx_q + 20'd1;
  // Low byte of word idx+1 lives at FL_BASE + 2*(idx+1), wrapping at 23 bits.
  assign fl_next_addr = FL_BASE + {2'b00, idx_inc, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 20'd0;
      cnt_q       <= 16'd0;
      lo_q        <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fl_addr_q   <= 23'd0;
      fl_ce_n_q   <= 1'b1;
      fl_oe_n_q   <= 1'b1;
      sram_addr_q <= 20'd0;
      sram_dq_q   <= 16'd0;
      dq_oe_q     <= 1'b0;
      sram_ce_n_q <= 1'b1;
      we_n_q      <= 1'b1;
      bytes_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            idx_q     <= 20'd0;
            cnt_q     <= 16'd0;
            fl_addr_q <= FL_BASE;
            fl_ce_n_q <= 1'b0;
            fl_oe_n_q <= 1'b0;
            state_q   <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (cnt_q == FL_LAST) begin
            lo_q      <= i_fl_dq;
            cnt_q     <= 16'd0;
            fl_addr_q <= fl_addr_q + 23'd1;
            state_q   <= S_RD_HI;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RD_HI: begin
          if (cnt_q == FL_LAST) begin
            // Flash is released in the same edge the SRAM bus is driven, so the
            // two drivers never overlap.
            sram_dq_q   <= {i_fl_dq, lo_q};
            sram_addr_q <= SRAM_BASE + idx_q;
            fl_ce_n_q   <= 1'b1;
            fl_oe_n_q   <= 1'b1;
            dq_oe_q     <= 1'b1;
            sram_ce_n_q <= 1'b0;
            bytes_n_q   <= 1'b0;
            cnt_q       <= 16'd0;
            state_q     <= S_SETUP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_SETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= 16'd0;
          state_q <= S_WE;
        end
        S_WE: begin
          if (cnt_q == WE_LAST) begin
            we_n_q  <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_HOLD: begin
          dq_oe_q     <= 1'b0;
          sram_ce_n_q <= 1'b1;
          bytes_n_q   <= 1'b1;
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q     <= idx_inc;
            cnt_q     <= 16'd0;
            fl_addr_q <= fl_next_addr;
            fl_ce_n_q <= 1'b0;
            fl_oe_n_q <= 1'b0;
            state_q   <= S_RD_LO;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_fl_addr    = fl_addr_q;
  assign o_fl_ce_n    = fl_ce_n_q;
  assign o_fl_oe_n    = fl_oe_n_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_dq    = sram_dq_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_ce_n  = sram_ce_n_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = 1'b1;  // this block only ever writes the SRAM
  assign o_sram_lb_n  = bytes_n_q;
  assign o_sram_ub_n  = bytes_n_q;

endmodule

// File: tb/tb_chr_sram_loader.sv
// Bench for chr_sram_loader: 4-word copy with both address spaces wrapping,
// behavioural flash (honours access time) and SRAM models, bus-protocol monitor.
module tb_chr_sram_loader;

  localparam logic [22:0] FLB   = 23'h7FFFFC;  // byte pairs straddle the 23-bit wrap
  localparam logic [19:0] SRB   = 20'hFFFFE;   // words straddle the 20-bit wrap
  localparam int          LEN   = 4;
  localparam int          FW    = 5;
  localparam int          WC    = 2;
  localparam int          TOTAL = LEN * (2 * FW + WC + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        o_busy, o_done;
  logic [22:0] o_fl_addr;
  logic        o_fl_ce_n, o_fl_oe_n;
  logic [7:0]  i_fl_dq = 8'hEE;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_sram_dq_oe, o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n;

  int n_cmp  = 0;
  int n_fail = 0;

  chr_sram_loader #(
    .FL_BASE(FLB), .SRAM_BASE(SRB), .LEN_WORDS(LEN), .FL_WAIT(FW), .WE_CYC(WC)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_fl_addr(o_fl_addr), .o_fl_ce_n(o_fl_ce_n), .o_fl_oe_n(o_fl_oe_n), .i_fl_dq(i_fl_dq),
    .o_sram_addr(o_sram_addr), .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  always #5 clk = ~clk;

  logic [7:0]  fmem [logic [22:0]];
  logic [15:0] smem [logic [19:0]];

  // Flash model: data is valid only once the address has been held with the
  // device enabled for FW cycles; before that it returns garbage.
  logic [22:0] fl_last_addr = 23'd0;
  int          fl_run = 0;
  always @(negedge clk) begin
    if (!o_fl_ce_n && !o_fl_oe_n) begin
      if (fl_run > 0 && o_fl_addr == fl_last_addr) fl_run++;
      else fl_run = 1;
      fl_last_addr = o_fl_addr;
      if (fl_run >= FW && fmem.exists(o_fl_addr)) i_fl_dq = fmem[o_fl_addr];
      else i_fl_dq = 8'hEE;
    end else begin
      fl_run  = 0;
      i_fl_dq = 8'hEE;
    end
  end

  // SRAM model and protocol monitor. A word commits when we_n returns high.
  int          we_run = 0;
  int          writes = 0;
  int          proto_err = 0;
  logic [19:0] w_addr, p_addr;
  logic [15:0] w_dat, p_dat;
  logic        p_oe = 1'b0, p_we_n = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      we_run = 0;
    end else begin
      if (o_sram_we_n === 1'b0) begin
        if (we_run == 0) begin
          w_addr = o_sram_addr;
          w_dat  = o_sram_dq;
          // one full setup cycle with the same address and data beforehand
          if (p_addr !== o_sram_addr || p_dat !== o_sram_dq || p_oe !== 1'b1 || p_we_n !== 1'b1)
            proto_err++;
        end else if (o_sram_addr !== w_addr || o_sram_dq !== w_dat) begin
          proto_err++;
        end
        if (o_sram_dq_oe !== 1'b1 || o_sram_ce_n !== 1'b0 || o_sram_lb_n !== 1'b0 || o_sram_ub_n !== 1'b0)
          proto_err++;
        we_run++;
      end else if (we_run != 0) begin
        // hold cycle: still driving the same word
        if (we_run != WC) proto_err++;
        if (o_sram_addr !== w_addr || o_sram_dq !== w_dat || o_sram_dq_oe !== 1'b1) proto_err++;
        smem[w_addr] = w_dat;
        writes++;
        we_run = 0;
      end
      if (o_sram_dq_oe === 1'b1 && o_fl_oe_n === 1'b0) proto_err++;
      if (o_sram_oe_n !== 1'b1) proto_err++;
    end
    p_addr = o_sram_addr;
    p_dat  = o_sram_dq;
    p_oe   = o_sram_dq_oe;
    p_we_n = o_sram_we_n;
  end

  function automatic logic [15:0] ref_word(input int k);
    logic [22:0] a_lo, a_hi;
    a_lo = 23'(FLB + 2 * k);
    a_hi = 23'(FLB + 2 * k + 1);
    return {fmem[a_hi], fmem[a_lo]};
  endfunction

  function automatic logic [15:0] sram_word(input int k);
    logic [19:0] a;
    a = 20'(SRB + k);
    if (smem.exists(a)) return smem[a];
    return 16'hxxxx;
  endfunction

  task automatic fill_flash(input bit fixed);
    for (int i = 0; i < 2 * LEN; i++)
      fmem[23'(FLB + i)] = fixed ? 8'((i + 1) * 17) : 8'($urandom);
  endtask

  // Pulses start and runs until o_done or a cycle budget; optionally pokes
  // start again at cycle `poke` after busy rose.
  task automatic run_copy(input int poke, output int cyc, output logic busy0,
                          output logic done0, output logic busy_last);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    busy0 = o_busy;
    done0 = o_done;
    busy_last = o_busy;
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 400) begin
      if (cyc == poke) i_start = 1'b1;
      busy_last = o_busy;
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    fill_flash(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_fl_addr, o_fl_ce_n, o_fl_oe_n} !== {23'd0, 2'b11}) begin
      n_fail++; $display("FAIL reset_flash: got %h %b %b want 000000 1 1", o_fl_addr, o_fl_ce_n, o_fl_oe_n);
    end
    n_cmp++;
    if ({o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe} !== 6'b111110) begin
      n_fail++; $display("FAIL reset_sram_ctl: got %b want 111110",
        {o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe});
    end
    n_cmp++;
    if ({o_sram_addr, o_sram_dq} !== 36'd0) begin
      n_fail++; $display("FAIL reset_sram_bus: got %h %h want 0 0", o_sram_addr, o_sram_dq);
    end
    n_cmp++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: got busy=%b done=%b want 0 0", o_busy, o_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_copy();
    int cyc; logic b0, d0, bl;
    fill_flash(1'b1);
    smem.delete();
    run_copy(-1, cyc, b0, d0, bl);
    n_cmp++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL small_busy_rise: got %b want 1", b0); end
    n_cmp++;
    if (cyc != TOTAL) begin n_fail++; $display("FAIL small_latency: got %0d want %0d", cyc, TOTAL); end
    n_cmp++;
    if ({bl, o_busy, o_done} !== 3'b101) begin
      n_fail++; $display("FAIL small_done_edge: got busy_prev/busy/done=%b want 101", {bl, o_busy, o_done});
    end
    for (int k = 0; k < LEN; k++) begin
      logic [15:0] want;
      want = 16'(((2 * k + 2) * 17) * 256 + (2 * k + 1) * 17);  // 2211, 4433, 6655, 8877
      n_cmp++;
      if (sram_word(k) !== want) begin
        n_fail++; $display("FAIL small_word%0d: got %h want %h", k, sram_word(k), want);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b1) begin n_fail++; $display("FAIL small_done_sticky: got %b want 1", o_done); end
  endtask

  task automatic test_random_copy();
    int cyc; logic b0, d0, bl;
    for (int r = 0; r < 3; r++) begin
      fill_flash(1'b0);
      smem.delete();
      writes = 0;
      run_copy(-1, cyc, b0, d0, bl);
      n_cmp++;
      if (cyc != TOTAL) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", r, cyc, TOTAL); end
      n_cmp++;
      if (writes != LEN) begin n_fail++; $display("FAIL rand%0d_writes: got %0d want %0d", r, writes, LEN); end
      for (int k = 0; k < LEN; k++) begin
        n_cmp++;
        if (sram_word(k) !== ref_word(k)) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h want %h", r, k, sram_word(k), ref_word(k));
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc; logic b0, d0, bl;
    fill_flash(1'b0);
    smem.delete();
    run_copy(30, cyc, b0, d0, bl);  // cycle 30 falls inside word 2
    n_cmp++;
    if (cyc != TOTAL) begin n_fail++; $display("FAIL busy_start_latency: got %0d want %0d", cyc, TOTAL); end
    for (int k = 0; k < LEN; k++) begin
      n_cmp++;
      if (sram_word(k) !== ref_word(k)) begin
        n_fail++; $display("FAIL busy_start_word%0d: got %h want %h", k, sram_word(k), ref_word(k));
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int cyc, guard; logic b0, d0, bl;
    fill_flash(1'b0);
    smem.delete();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    guard = 0;
    while (!(o_sram_we_n === 1'b0 && o_sram_addr === 20'(SRB + 2)) && guard < 200) begin
      @(negedge clk); guard++;
    end
    n_cmp++;
    if (guard >= 200) begin n_fail++; $display("FAIL midrst_reach_we: got timeout want word2 WE"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_sram_we_n, o_sram_dq_oe, o_busy, o_done} !== 4'b1000) begin
      n_fail++; $display("FAIL midrst_async: got we_n/dq_oe/busy/done=%b want 1000",
        {o_sram_we_n, o_sram_dq_oe, o_busy, o_done});
    end
    n_cmp++;
    if (smem.exists(20'(SRB + 2))) begin
      n_fail++; $display("FAIL midrst_partial: got word2 written want not written");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    smem.delete();
    run_copy(-1, cyc, b0, d0, bl);
    n_cmp++;
    if (cyc != TOTAL) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", cyc, TOTAL); end
    for (int k = 0; k < LEN; k++) begin
      n_cmp++;
      if (sram_word(k) !== ref_word(k)) begin
        n_fail++; $display("FAIL midrst_word%0d: got %h want %h", k, sram_word(k), ref_word(k));
      end
    end
  endtask

  task automatic test_restart_after_done();
    int cyc; logic b0, d0, bl;
    logic [15:0] snap [LEN];
    n_cmp++;
    if (o_done !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done: got %b want 1", o_done); end
    for (int k = 0; k < LEN; k++) snap[k] = sram_word(k);
    smem.delete();
    run_copy(-1, cyc, b0, d0, bl);
    n_cmp++;
    if ({b0, d0} !== 2'b10) begin
      n_fail++; $display("FAIL restart_done_drop: got busy/done=%b want 10", {b0, d0});
    end
    n_cmp++;
    if (cyc != TOTAL) begin n_fail++; $display("FAIL restart_latency: got %0d want %0d", cyc, TOTAL); end
    for (int k = 0; k < LEN; k++) begin
      n_cmp++;
      if (sram_word(k) !== snap[k]) begin
        n_fail++; $display("FAIL restart_word%0d: got %h want %h", k, sram_word(k), snap[k]);
      end
    end
  endtask

  task automatic test_bus_protocol();
    n_cmp++;
    if (proto_err != 0) begin
      n_fail++; $display("FAIL bus_protocol: got %0d violations want 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_small_copy();
    test_random_copy();
    test_start_while_busy();
    test_reset_mid_copy();
    test_restart_after_done();
    test_bus_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
